// File: rtl/clk_div_controller.sv
// clk_div_controller: run-time clock-enable divider with glitch-free ratio reload and graceful stop.
// divided_clk always parks low in IDLE; ratio changes take effect only at period boundaries.
module clk_div_controller #(
    parameter int                CNT_W       = 21,
    parameter logic [CNT_W-1:0]  DEFAULT_DIV = 21'h1FFFFF,
    parameter int                TICK_CNT_W  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_valid,
    input  logic [CNT_W-1:0]      cfg_div,
    output logic                  cfg_ready,
    output logic                  tick,
    output logic                  divided_clk,
    output logic                  running,
    output logic [TICK_CNT_W-1:0] tick_count
);
    typedef enum logic [1:0] {IDLE, RUN, STOP_WAIT} state_t;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d;
    logic                  pending_q, pending_d, tick_q, tick_d, dclk_q, dclk_d, running_q, running_d;
    logic [TICK_CNT_W-1:0] tcnt_q, tcnt_d;
    logic                  active, tc, accept, launch, leaving;
    assign active    = state_q != IDLE;
    assign tc        = active && cnt_q == div_q;
    assign accept    = cfg_valid && !pending_q;
    assign launch    = state_q == IDLE && start && !stop;
    assign leaving   = active && state_d == IDLE;
    assign cfg_ready   = ~pending_q;
    assign tick        = tick_q;
    assign divided_clk = dclk_q;
    assign running     = running_q;
    assign tick_count  = tcnt_q;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // stop decision uses the divided_clk level this edge will produce
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (launch) state_d = RUN;
            RUN:       if (stop) state_d = (tc ? !dclk_q : dclk_q) ? STOP_WAIT : IDLE;
            STOP_WAIT: if (tc) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d     = (!active || leaving || tc) ? '0 : cnt_q + 1'b1;
        tick_d    = tc;
        dclk_d    = dclk_q ^ tc;
        tcnt_d    = launch ? '0 : tcnt_q + TICK_CNT_W'(tc);
        running_d = state_d != IDLE;
        div_d     = div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // a ratio still queued when dividing ends is committed so IDLE never holds a pending value
        if (!active) begin
            div_d = accept ? cfg_div : div_q;
        end else if (leaving) begin
            div_d     = accept ? cfg_div : (pending_q ? shadow_q : div_q);
            pending_d = 1'b0;
        end else begin
            if (tc && pending_q) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
            end
            if (accept) begin
                shadow_d  = cfg_div;
                pending_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= DEFAULT_DIV;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            dclk_q    <= 1'b0;
            running_q <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            dclk_q    <= dclk_d;
            running_q <= running_d;
            tcnt_q    <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_clk_div_controller.sv
// tb_clk_div_controller: directed scoreboard bench for clk_div_controller.
module tb_clk_div_controller;
    logic        clk_in = 1'b0;
    logic        rst_n, start, stop, cfg_valid;
    logic [20:0] cfg_div;
    logic        cfg_ready, tick, divided_clk, running;
    logic [7:0]  tick_count;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        string      tag;
        logic       tk;
        logic       dc;
        logic       rn;
        logic       rd;
        logic [7:0] tc;
    } exp_t;
    exp_t sb[$];

    clk_div_controller #(.CNT_W(21), .DEFAULT_DIV(21'd9), .TICK_CNT_W(8)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .tick(tick), .divided_clk(divided_clk), .running(running),
        .tick_count(tick_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic tk, input logic dc, input logic rn,
                        input logic rd, input logic [7:0] tc);
        exp_t e;
        e.tag = tag; e.tk = tk; e.dc = dc; e.rn = rn; e.rd = rd; e.tc = tc;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".tick"}, 32'(tick), 32'(e.tk));
            cmp({e.tag, ".divided_clk"}, 32'(divided_clk), 32'(e.dc));
            cmp({e.tag, ".running"}, 32'(running), 32'(e.rn));
            cmp({e.tag, ".cfg_ready"}, 32'(cfg_ready), 32'(e.rd));
            cmp({e.tag, ".tick_count"}, 32'(tick_count), 32'(e.tc));
        end
    endtask

    task automatic step(input string tag, input logic tk, input logic dc, input logic rn,
                        input logic rd, input logic [7:0] tc);
        push(tag, tk, dc, rn, rd, tc);
        cyc();
        check_out();
    endtask

    task automatic drain();
        while (sb.size() != 0) begin
            cyc();
            check_out();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (3) cyc();
        push("rst_hold", 0, 0, 0, 1, 0); check_out();
        @(negedge clk_in); rst_n = 1'b1;
        step("rst_rel", 0, 0, 0, 1, 0);

        // basic divide by 4
        cfg_valid = 1'b1; cfg_div = 21'd3;
        cyc(); cfg_valid = 1'b0;
        push("cfg3_idle", 0, 0, 0, 1, 0); check_out();
        start = 1'b1; cyc(); start = 1'b0;
        push("start3", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 20; k++) push("div3", k % 4 == 0, (k / 4) % 2 == 1, 1, 1, 8'(k / 4));
        drain();

        // live reload 3 -> 1, second offer while pending is refused
        step("reload_k21", 0, 1, 1, 1, 5);
        cfg_valid = 1'b1; cfg_div = 21'd1;
        step("reload_acc", 0, 1, 1, 0, 5);
        cfg_div = 21'd0;
        step("reload_busy", 0, 1, 1, 0, 5);
        cfg_valid = 1'b0;
        step("reload_apply", 1, 0, 1, 1, 6);
        for (int k = 25; k <= 30; k++)
            push("div1", k % 2 == 0, ((k - 24) / 2) % 2 == 1, 1, 1, 8'(6 + (k - 24) / 2));
        drain();
        stop = 1'b1;
        step("sw_div1_a", 0, 1, 1, 1, 9);
        step("sw_div1_b", 1, 0, 0, 1, 10);
        stop = 1'b0;
        step("idle_after", 0, 0, 0, 1, 10);

        // graceful stop with divided_clk high, div=5
        cfg_valid = 1'b1; cfg_div = 21'd5;
        cyc(); cfg_valid = 1'b0;
        push("cfg5_idle", 0, 0, 0, 1, 10); check_out();
        start = 1'b1; cyc(); start = 1'b0;
        push("start5", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 13; k++) begin
            step("stopwait5", k == 6 || k == 12, k >= 6 && k < 12, k < 12, 1,
                 8'(k >= 12 ? 2 : (k >= 6 ? 1 : 0)));
            if (k == 7) stop = 1'b1;
        end
        stop = 1'b0;

        // stop with divided_clk low goes straight to IDLE without a tick
        start = 1'b1; cyc(); start = 1'b0;
        push("start5b", 0, 0, 1, 1, 0); check_out();
        step("stoplow_k1", 0, 0, 1, 1, 0);
        step("stoplow_k2", 0, 0, 1, 1, 0);
        stop = 1'b1;
        step("stoplow_k3", 0, 0, 0, 1, 0);
        step("stoplow_k4", 0, 0, 0, 1, 0);
        stop = 1'b0;

        // div=0: tick every cycle; stop at a terminal count with pre-toggle low
        cfg_valid = 1'b1; cfg_div = 21'd0;
        cyc(); cfg_valid = 1'b0;
        push("cfg0_idle", 0, 0, 0, 1, 0); check_out();
        start = 1'b1; cyc(); start = 1'b0;
        push("start0", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 6; k++) push("div0", 1, k % 2 == 1, 1, 1, 8'(k));
        drain();
        stop = 1'b1;
        step("stop0_sw", 1, 1, 1, 1, 7);
        step("stop0_idle", 1, 0, 0, 1, 8);
        stop = 1'b0;
        step("stop0_after", 0, 0, 0, 1, 8);

        // start and stop together in IDLE stays IDLE
        start = 1'b1; stop = 1'b1;
        step("startstop_a", 0, 0, 0, 1, 8);
        step("startstop_b", 0, 0, 0, 1, 8);
        start = 1'b0; stop = 1'b0;

        // tick_count wrap 255 -> 0
        start = 1'b1; cyc(); start = 1'b0;
        push("start_wrap", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 256; k++) push("wrap", 1, k % 2 == 1, 1, 1, 8'(k));
        drain();
        stop = 1'b1;
        step("wrap_sw", 1, 1, 1, 1, 1);
        step("wrap_idle", 1, 0, 0, 1, 2);
        stop = 1'b0;
        step("wrap_after", 0, 0, 0, 1, 2);

        // async reset mid-run with a ratio pending
        cfg_valid = 1'b1; cfg_div = 21'd7;
        cyc(); cfg_valid = 1'b0;
        push("cfg7_idle", 0, 0, 0, 1, 2); check_out();
        start = 1'b1; cyc(); start = 1'b0;
        push("start7", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 12; k++) begin
            step("div7", k == 8, k >= 8, 1, !(k >= 10), 8'(k >= 8 ? 1 : 0));
            if (k == 9) begin cfg_valid = 1'b1; cfg_div = 21'd2; end
            if (k == 10) cfg_valid = 1'b0;
        end
        #2; rst_n = 1'b0; #1;
        push("async_rst", 0, 0, 0, 1, 0); check_out();
        cyc();
        @(negedge clk_in); rst_n = 1'b1;
        step("rst2_rel", 0, 0, 0, 1, 0);
        start = 1'b1; cyc(); start = 1'b0;
        push("start_dflt", 0, 0, 1, 1, 0); check_out();
        for (int k = 1; k <= 10; k++) push("dflt_div", k == 10, k == 10, 1, 1, 8'(k == 10 ? 1 : 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
